// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with a registered read port, occupancy count, threshold flags
// and sticky overflow/underflow error flags.
module sync_fifo_buffer #(
    parameter int w_address = 4,
    parameter int w_data    = 8,
    parameter int L_fifo    = 16,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [w_data-1:0]    WRITE_DATA,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [w_data-1:0]    READ_DATA,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [w_address:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [w_address:0] DEPTH    = (w_address+1)'(L_fifo);
    localparam logic [w_address:0] AF_LIMIT = (w_address+1)'(AF_LEVEL);
    localparam logic [w_address:0] AE_LIMIT = (w_address+1)'(AE_LEVEL);
    localparam logic [w_address:0] ONE      = (w_address+1)'(1);

    logic [w_data-1:0]  mem [L_fifo];
    logic [w_address:0] write_pointer;
    logic [w_address:0] read_pointer;
    logic [w_address:0] count_q;
    logic               wr_ok;
    logic               rd_ok;

    // Status comes only from the count register, so no enable-to-flag path exists.
    assign full         = (count_q == DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LIMIT);
    assign almost_empty = (count_q <= AE_LIMIT);
    assign count        = count_q;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[write_pointer[w_address-1:0]] <= WRITE_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            count_q       <= '0;
            READ_DATA     <= '0;
            rd_valid      <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_ok) begin
                write_pointer <= write_pointer + ONE;
            end

            if (rd_ok) begin
                READ_DATA    <= mem[read_pointer[w_address-1:0]];
                read_pointer <= read_pointer + ONE;
                rd_valid     <= 1'b1;
            end else begin
                rd_valid     <= 1'b0;
            end

            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase

            // A new error in the same cycle as clr_err keeps the flag set.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer: directed scenarios plus random traffic,
// all compared against a queue-based model of the FIFO.
module tb_sync_fifo_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] WRITE_DATA = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] READ_DATA;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q [$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         m_rv  = 1'b0;
    logic [7:0] m_rd  = '0;

    sync_fifo_buffer #(
        .w_address(4), .w_data(8), .L_fifo(16), .AF_LEVEL(12), .AE_LEVEL(4)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .WRITE_DATA(WRITE_DATA),
        .rd_en(rd_en), .clr_err(clr_err), .READ_DATA(READ_DATA),
        .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_vec();
        int n = q.size();
        return {n == 16, n == 0, n >= 12, n <= 4, 5'(n), m_ovf, m_udf, m_rv, m_rd};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {full, empty, almost_full, almost_empty, count,
                overflow, underflow, rd_valid, READ_DATA};
    endfunction

    // Applies one cycle of stimulus and advances the model by the same edge.
    task automatic step(input logic w, input logic r, input logic c,
                        input logic s, input logic [7:0] d);
        bit was_full, was_empty;
        wr_en = w; rd_en = r; clr_err = c; rst = s; WRITE_DATA = d;
        @(posedge clk);
        if (s) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_rd = '0;
        end else begin
            was_full  = (q.size() == 16);
            was_empty = (q.size() == 0);
            if (r && !was_empty) begin
                m_rd = q.pop_front();
                m_rv = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (w && !was_full) q.push_back(d);
            if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
            if (r && was_empty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1, 1, 8'h5A);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_status: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_count: got count=%0d empty=%b ovf=%b udf=%b expected 0 1 0 0",
                     count, empty, overflow, underflow);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 8'(i));
            n_cmp++;
            if (dut_vec() !== exp_vec() || full !== (i == 15) || almost_full !== (i >= 11)) begin
                n_bad++;
                $display("FAIL fill_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 8'h00);
            n_cmp++;
            if (dut_vec() !== exp_vec() || READ_DATA !== 8'(i) || rd_valid !== 1'b1
                || almost_empty !== (i >= 11)) begin
                n_bad++;
                $display("FAIL drain_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            n_bad++;
            $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 8'($urandom));
        n_cmp++;
        if (overflow !== 1'b1 || count !== 5'd16 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL overflow: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 8'h00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL ovf_drain_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        step(0, 1, 0, 0, 8'h00);
        n_cmp++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL underflow: got %h expected %h", dut_vec(), exp_vec());
        end
        step(0, 0, 1, 0, 8'h00);
        n_cmp++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL clr_err: got ovf=%b udf=%b expected 0 0", overflow, underflow);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0, 0, 8'($urandom));
            n_cmp++;
            if (count !== 5'd8 || rd_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 8'h00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_drain_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] first;
        step(0, 0, 1, 0, 8'h00);
        first = 8'($urandom);
        step(1, 1, 0, 0, first);
        n_cmp++;
        if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0
            || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL sim_empty: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 8'($urandom));
        step(1, 1, 0, 0, 8'hEE);
        n_cmp++;
        if (count !== 5'd15 || overflow !== 1'b1 || rd_valid !== 1'b1
            || READ_DATA !== first || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL sim_full: got %h rd=%h expected %h rd=%h",
                     dut_vec(), READ_DATA, exp_vec(), first);
        end
        step(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'($urandom));
        step(0, 0, 0, 1, 8'h00);
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL mid_reset: got count=%0d empty=%b expected 0 1", count, empty);
        end
        step(1, 0, 0, 0, 8'hA5);
        step(0, 1, 0, 0, 8'h00);
        n_cmp++;
        if (READ_DATA !== 8'hA5 || rd_valid !== 1'b1 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_read: got %h valid=%b expected a5 1", READ_DATA, rd_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 5), ($urandom_range(0, 199) == 0),
                 8'($urandom));
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
